// File: rtl/status_scan_display_pkg.sv
// status_scan_display_pkg
//   Shared definitions for the status scan display: the hex glyph table for
//   an active-low {dp,g,f,e,d,c,b,a} seven-segment digit, the blank
//   patterns for segments and digit enables, and the channel FSM encoding.
package status_scan_display_pkg;

  typedef enum logic {
    ST_AUTO = 1'b0,  // rotate through channels every DWELL_FRAMES frames
    ST_HOLD = 1'b1   // frozen on the current channel
  } chan_state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [2:0] DIG_OFF = 3'b111;

  // Entry n is the glyph for hex digit n (b and d are lower-case).
  // dp (bit 7) is 1, i.e. dark, in every entry.
  localparam logic [15:0][7:0] HEX_GLYPH = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
    8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
    8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
    8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
  };

endpackage

// File: rtl/status_scan_display_if.sv
// status_scan_display_if
//   Bundles the status bytes, channel-select strobe, LED events and the
//   display/LED outputs of status_scan_display.
//   Inputs : status_in (N_CH bytes, channel k on [8k+7:8k]), hold,
//            sel_valid, sel_ch, led_evt
//   Outputs: cur_ch, segments, segments_enable, led_out, dbg_state
//
//   Handshake: sel_valid is a single-cycle strobe with no ready. A strobe
//   whose sel_ch is below N_CH is always taken on the edge it is sampled;
//   a strobe with sel_ch >= N_CH is dropped without effect.
interface status_scan_display_if #(
  parameter int N_CH = 4
);
  import status_scan_display_pkg::*;

  logic [N_CH*8-1:0] status_in;
  logic              hold;
  logic              sel_valid;
  logic [3:0]        sel_ch;
  logic [7:0]        led_evt;
  logic [3:0]        cur_ch;
  logic [7:0]        segments;
  logic [2:0]        segments_enable;
  logic [7:0]        led_out;
  chan_state_e       dbg_state;

  modport master (
    output status_in, hold, sel_valid, sel_ch, led_evt,
    input  cur_ch, segments, segments_enable, led_out, dbg_state
  );

  modport slave (
    input  status_in, hold, sel_valid, sel_ch, led_evt,
    output cur_ch, segments, segments_enable, led_out, dbg_state
  );
endinterface

// File: rtl/status_scan_display_seg_decode.sv
// status_scan_display_seg_decode
//   Combinational hex nibble to active-low seven-segment pattern.
//   i_nibble : hex digit 0-F
//   i_dp     : 1 = light the decimal point
//   o_seg    : {dp,g,f,e,d,c,b,a}, active-low
module status_scan_display_seg_decode
  import status_scan_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  assign o_seg = HEX_GLYPH[i_nibble] & {~i_dp, 7'h7F};

endmodule

// File: rtl/status_scan_display.sv
// status_scan_display
//   Shows one of N_CH status bytes on a multiplexed 3-digit seven-segment
//   panel: digit 2 = channel index, digits 1..0 = byte in hex. Rotates
//   through the channels every DWELL_FRAMES frames or holds on one; a
//   sel_valid strobe jumps straight to a channel. Also drives 8 LEDs from
//   event inputs.
//   Ports: clk, reset (async, active-low), bus (status_scan_display_if.slave).
//   Build option: define PULSE_STRETCH_EN to stretch every LED event to at
//   least STRETCH_CYCLES clock cycles; otherwise led_out is led_evt delayed
//   by one register.
module status_scan_display
  import status_scan_display_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int SYS_CLK_FREQ   = 125000000,
  parameter int REFRESH_RATE   = 100,
  parameter int DWELL_FRAMES   = 200,
  parameter int BLANK_CYCLES   = 16,
  parameter int STRETCH_CYCLES = 6250000
) (
  input  logic                  clk,
  input  logic                  reset,
  status_scan_display_if.slave  bus
);

  localparam int SLOT_RAW = SYS_CLK_FREQ / (REFRESH_RATE * 3);
  localparam int SLOT     = (SLOT_RAW < 2) ? 2 : SLOT_RAW;
  localparam int BLANK    = (BLANK_CYCLES > SLOT - 1) ? SLOT - 1 : BLANK_CYCLES;
  localparam int SW       = $clog2(SLOT);
  localparam int FW       = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

  if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
    $error("status_scan_display: N_CH must be 1..16");
  end
  if (STRETCH_CYCLES < 1) begin : g_bad_stretch
    $error("status_scan_display: STRETCH_CYCLES must be at least 1");
  end

  logic [SW-1:0] r_slot_cnt;
  logic [1:0]    r_digit;
  logic [7:0]    r_snap;
  logic [7:0]    r_seg;
  logic [2:0]    r_en;
  chan_state_e   r_state;
  logic [3:0]    r_cur_ch;
  logic [FW-1:0] r_frame_cnt;
  logic [7:0]    r_led_evt;

  logic          w_slot_wrap;
  logic          w_frame_end;
  logic [SW-1:0] w_slot_nxt;
  logic [1:0]    w_digit_nxt;
  logic          w_sel_ok;
  logic          w_dwell_done;
  logic [3:0]    w_ch_nxt;
  logic [7:0]    w_sel_byte;
  logic [7:0]    w_snap_nxt;
  logic [3:0]    w_nibble;
  logic          w_dp;
  logic [7:0]    w_seg_pat;
  logic [7:0]    w_led;

  assign w_slot_wrap = (r_slot_cnt == SW'(SLOT - 1));
  assign w_frame_end = w_slot_wrap && (r_digit == 2'd2);
  assign w_slot_nxt  = w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
  assign w_digit_nxt = !w_slot_wrap ? r_digit :
                       (r_digit == 2'd2) ? 2'd0 : r_digit + 2'd1;

  assign w_sel_ok     = bus.sel_valid && ({28'd0, bus.sel_ch} < N_CH);
  assign w_dwell_done = (r_state == ST_AUTO) && !bus.hold && w_frame_end &&
                        (r_frame_cnt == FW'(DWELL_FRAMES - 1));

  // sel_valid takes priority over an auto-advance on the same edge.
  always_comb begin
    w_ch_nxt = r_cur_ch;
    if (w_sel_ok)
      w_ch_nxt = bus.sel_ch;
    else if (w_dwell_done)
      w_ch_nxt = (r_cur_ch == 4'(N_CH - 1)) ? 4'd0 : r_cur_ch + 4'd1;
  end

  always_comb begin
    w_sel_byte = 8'h00;
    for (int k = 0; k < N_CH; k++)
      if (w_ch_nxt == 4'(k)) w_sel_byte = bus.status_in[8*k +: 8];
  end

  // The snapshot is taken on the edge that enters digit slot 0, using the
  // channel that becomes current on that same edge, so a frame that starts
  // right after an advance already shows the new channel's byte.
  assign w_snap_nxt = (w_slot_wrap && w_digit_nxt == 2'd0) ? w_sel_byte : r_snap;

  // The pattern is computed for the slot about to start and latched at the
  // wrap, so segments never change inside a slot.
  always_comb begin
    w_nibble = w_snap_nxt[3:0];
    w_dp     = 1'b0;
    case (w_digit_nxt)
      2'd1: w_nibble = w_snap_nxt[7:4];
      2'd2: begin
        w_nibble = w_ch_nxt;
        w_dp     = bus.hold;
      end
      default: ;
    endcase
  end

  status_scan_display_seg_decode u_seg_decode (
    .i_nibble (w_nibble),
    .i_dp     (w_dp),
    .o_seg    (w_seg_pat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_slot_cnt <= '0;
      r_digit    <= 2'd0;
      r_snap     <= 8'h00;
      r_seg      <= SEG_OFF;
      r_en       <= DIG_OFF;
    end else begin
      r_slot_cnt <= w_slot_nxt;
      r_digit    <= w_digit_nxt;
      r_snap     <= w_snap_nxt;
      if (w_slot_wrap) r_seg <= w_seg_pat;
      // Blank all digits for the first BLANK cycles of a slot so the old
      // pattern never ghosts onto the newly enabled digit.
      r_en <= (w_slot_nxt < SW'(BLANK)) ? DIG_OFF : ~(3'b001 << w_digit_nxt);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_AUTO;
      r_cur_ch    <= 4'd0;
      r_frame_cnt <= '0;
    end else begin
      r_cur_ch <= w_ch_nxt;
      case (r_state)
        ST_AUTO: begin
          if (bus.hold)
            r_state <= ST_HOLD;
          else if (w_frame_end)
            r_frame_cnt <= w_dwell_done ? '0 : r_frame_cnt + 1'b1;
        end
        ST_HOLD: begin
          if (!bus.hold) begin
            r_state     <= ST_AUTO;
            r_frame_cnt <= '0;
          end
        end
        default: r_state <= ST_AUTO;
      endcase
      if (w_sel_ok) r_frame_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_led_evt <= 8'h00;
    else        r_led_evt <= bus.led_evt;
  end

`ifdef PULSE_STRETCH_EN
  localparam int CW = $clog2(STRETCH_CYCLES + 1);

  // The counter loads from the registered event, so the registered event
  // covers the first lit cycle and the counter the remaining
  // STRETCH_CYCLES-1.
  for (genvar g = 0; g < 8; g++) begin : g_stretch
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)
        r_cnt <= '0;
      else if (r_led_evt[g])
        r_cnt <= CW'(STRETCH_CYCLES - 1);
      else if (r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end

    assign w_led[g] = (r_cnt != '0) || r_led_evt[g];
  end
`else
  assign w_led = r_led_evt;
`endif

  assign bus.cur_ch          = r_cur_ch;
  assign bus.segments        = r_seg;
  assign bus.segments_enable = r_en;
  assign bus.led_out         = w_led;
  assign bus.dbg_state       = r_state;

endmodule

// File: tb/tb_status_scan_display.sv
// tb_status_scan_display
//   Directed bench for status_scan_display with SLOT=10, BLANK=2,
//   DWELL_FRAMES=2, N_CH=3, STRETCH_CYCLES=8. cyc counts rising edges since
//   the last reset release; all sampling happens 1 time unit after an edge.
module tb_status_scan_display;
  import status_scan_display_pkg::*;

`ifdef PULSE_STRETCH_EN
  localparam int EXP_SINGLE = 8;
  localparam int EXP_RETRIG = 13;
`else
  localparam int EXP_SINGLE = 1;
  localparam int EXP_RETRIG = 2;
`endif

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_errors;

  status_scan_display_if #(.N_CH(3)) bus ();

  status_scan_display #(
    .N_CH           (3),
    .SYS_CLK_FREQ   (3000),
    .REFRESH_RATE   (100),
    .DWELL_FRAMES   (2),
    .BLANK_CYCLES   (2),
    .STRETCH_CYCLES (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cyc=%0d, required end before limit", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cyc=%0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic led_burst(input int retrig_at, output int n_hi);
    logic [7:0] others;
    bus.led_evt = 8'h08;
    tick();
    bus.led_evt = 8'h00;
    check("led_start", bus.led_out, 8'h08);
    n_hi   = 0;
    others = 8'h00;
    for (int i = 0; i < 25; i++) begin
      if (bus.led_out[3]) n_hi++;
      others |= bus.led_out & 8'hF7;
      bus.led_evt = (i == retrig_at) ? 8'h08 : 8'h00;
      tick();
    end
    bus.led_evt = 8'h00;
    check("led_other_bits", others, 8'h00);
  endtask

  // ---------------- stimulus ----------------
  int bad;
  int n_hi;

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    cyc           = 0;
    reset         = 1'b0;
    bus.status_in = {8'h3C, 8'hA5, 8'h00};
    bus.hold      = 1'b0;
    bus.sel_valid = 1'b0;
    bus.sel_ch    = 4'd0;
    bus.led_evt   = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_seg",   bus.segments, 8'hFF);
    check("rst_en",    bus.segments_enable, 3'b111);
    check("rst_ch",    bus.cur_ch, 4'd0);
    check("rst_led",   bus.led_out, 8'h00);
    check("rst_state", bus.dbg_state, ST_AUTO);
    reset = 1'b1;
    cyc   = 0;

    // Frame 0: first slot is dark (pattern only loads at a slot wrap).
    run_to(1);  check("f0_blank_en", bus.segments_enable, 3'b111);
                check("f0_d0_seg",   bus.segments, 8'hFF);
    run_to(2);  check("f0_d0_en",    bus.segments_enable, 3'b110);
    run_to(10); check("f0_d1_seg",   bus.segments, 8'hC0);
                check("f0_d1_blank", bus.segments_enable, 3'b111);
    run_to(12); check("f0_d1_en",    bus.segments_enable, 3'b101);
    run_to(20); check("f0_d2_seg",   bus.segments, 8'hC0);
    run_to(22); check("f0_d2_en",    bus.segments_enable, 3'b011);
    run_to(30); check("f1_d0_seg",   bus.segments, 8'hC0);

    // Auto-rotate and channel 1 content, with snapshot consistency.
    run_to(59);  check("ch_before_60", bus.cur_ch, 4'd0);
    run_to(60);  check("ch_at_60",     bus.cur_ch, 4'd1);
                 check("ch1_d0",       bus.segments, 8'h92);
    run_to(65);  bus.status_in = {8'h3C, 8'hFF, 8'h00};
    run_to(70);  check("snap_d1_held", bus.segments, 8'h88);
    run_to(80);  check("ch1_d2",       bus.segments, 8'hF9);
    run_to(90);  check("snap_new_d0",  bus.segments, 8'h8E);
    run_to(100); check("snap_new_d1",  bus.segments, 8'h8E);
    run_to(119); check("ch_before_120", bus.cur_ch, 4'd1);
    run_to(120); check("ch_at_120",    bus.cur_ch, 4'd2);
                 check("ch2_d0",       bus.segments, 8'hC6);
    run_to(130); check("ch2_d1",       bus.segments, 8'hB0);
    run_to(140); check("ch2_d2",       bus.segments, 8'hA4);
    run_to(179); check("ch_before_180", bus.cur_ch, 4'd2);
    run_to(180); check("ch_at_180",    bus.cur_ch, 4'd0);

    // Hold on channel 2 (reached at 300) for 1000 cycles.
    run_to(305); bus.hold = 1'b1;
    run_to(306); check("hold_state", bus.dbg_state, ST_HOLD);
    bad = 0;
    while (cyc < 1306) begin
      tick();
      if (bus.cur_ch !== 4'd2) bad++;
      if (cyc == 321) check("hold_d2_dp", bus.segments, 8'h24);
      if (cyc == 331) check("hold_d0_nodp", bus.segments, 8'hC6);
      if (cyc == 341) check("hold_d1_nodp", bus.segments, 8'hB0);
    end
    check("hold_stay", bad, 0);

    // Release sampled on the frame-end edge 1320: advance exactly 60 later.
    run_to(1319); bus.hold = 1'b0;
    run_to(1320); check("unhold_state", bus.dbg_state, ST_AUTO);
    run_to(1340); check("unhold_d2_nodp", bus.segments, 8'hA4);
    run_to(1379); check("unhold_ch_1379", bus.cur_ch, 4'd2);
    run_to(1380); check("unhold_ch_1380", bus.cur_ch, 4'd0);

    // sel_valid: valid jump, out-of-range ignored, wins over auto-advance.
    run_to(1385); bus.sel_valid = 1'b1; bus.sel_ch = 4'd1;
    run_to(1386); bus.sel_valid = 1'b0;
    check("sel_1", bus.cur_ch, 4'd1);
    run_to(1390); bus.sel_valid = 1'b1; bus.sel_ch = 4'd5;
    run_to(1391); bus.sel_valid = 1'b0;
    check("sel_5_ignored", bus.cur_ch, 4'd1);
    run_to(1439); bus.sel_valid = 1'b1; bus.sel_ch = 4'd0;
    run_to(1440); bus.sel_valid = 1'b0;
    check("sel_beats_advance", bus.cur_ch, 4'd0);
    run_to(1499); check("sel_clr_1499", bus.cur_ch, 4'd0);
    run_to(1500); check("sel_clr_1500", bus.cur_ch, 4'd1);

    // Asynchronous reset in the middle of a slot.
    run_to(1505); check("pre_rst_seg", bus.segments, 8'h8E);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_seg", bus.segments, 8'hFF);
    check("midrst_en",  bus.segments_enable, 3'b111);
    check("midrst_ch",  bus.cur_ch, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc   = 0;

    // LED events.
    run_to(5);
    check("led_idle", bus.led_out, 8'h00);
    led_burst(-1, n_hi);
    check("led_single_len", n_hi, EXP_SINGLE);
    run_to(cyc + 5);
    led_burst(4, n_hi);
    check("led_retrig_len", n_hi, EXP_RETRIG);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
